// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  localparam int unsigned LSU_DATA_WIDTH = 32;
  localparam int unsigned LSU_ADDR_WIDTH = 4;
  localparam int unsigned LSU_LEN_WIDTH  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake bundle between a requester and the load/store unit.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int unsigned data_width = LSU_DATA_WIDTH,
  parameter int unsigned addr_width = LSU_ADDR_WIDTH,
  parameter int unsigned len_width  = LSU_LEN_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [addr_width-1:0] req_addr;
  logic [len_width-1:0]  req_len;
  logic [data_width-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [data_width-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/lsu_beat_counter.sv
// Burst address / remaining-beat counter; address wraps modulo the memory size.
// Latency: load and step take effect on the next clock edge.
// Backpressure: none; advances only when the caller pulses step.
module lsu_beat_counter
  import lsu_pkg::*;
#(
  parameter int unsigned addr_width = LSU_ADDR_WIDTH,
  parameter int unsigned len_width  = LSU_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [addr_width-1:0] load_addr,
  input  logic [len_width-1:0]  load_len,
  output logic [addr_width-1:0] addr_q,
  output logic                  last
);
  logic [len_width-1:0] beats_q;

  // Latch start address/length on load; on step move to the next word and consume a beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else if (load) begin
      addr_q  <= load_addr;
      beats_q <= load_len;
    end else if (step) begin
      addr_q  <= addr_q + addr_width'(1);
      beats_q <= beats_q - len_width'(1);
    end
  end

  // The beat being worked on is the final one when no further beats remain.
  always_comb begin
    last = (beats_q == '0);
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-word store / burst load engine in front of a synchronous one-cycle-latency RAM.
// Latency: store writes the cycle after acceptance; each load beat appears 3 cycles after acceptance or the previous beat.
// Backpressure: one request in flight (req_ready only in IDLE); a beat is held stable until rsp_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned data_width = LSU_DATA_WIDTH,
  parameter int unsigned addr_width = LSU_ADDR_WIDTH,
  parameter int unsigned len_width  = LSU_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  lsu_if.slave                  bus,
  output logic [addr_width-1:0] mem_read_address,
  output logic [addr_width-1:0] mem_write_address,
  output logic                  mem_write,
  output logic [data_width-1:0] mem_din,
  input  logic [data_width-1:0] mem_dout
);
  lsu_state_t            state, state_n;
  logic                  wr_q;
  logic [data_width-1:0] wdata_q;
  logic [data_width-1:0] rdata_q;
  logic [addr_width-1:0] addr_q;
  logic                  last;
  logic                  req_fire;
  logic                  beat_fire;

  assign req_fire  = bus.req_valid && bus.req_ready;
  assign beat_fire = bus.rsp_valid && bus.rsp_ready;

  lsu_beat_counter #(
    .addr_width (addr_width),
    .len_width  (len_width)
  ) u_beat_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (req_fire),
    .step      (beat_fire && !last),
    .load_addr (bus.req_addr),
    .load_len  (bus.req_len),
    .addr_q    (addr_q),
    .last      (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: store takes one WRITE cycle; each load beat walks RD_ADDR -> RD_DATA -> RESP.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_fire) state_n = bus.req_write ? WRITE : RD_ADDR;
      WRITE:   state_n = IDLE;
      RD_ADDR: state_n = RD_DATA;
      RD_DATA: state_n = RESP;
      RESP:    if (beat_fire) state_n = last ? IDLE : RD_ADDR;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: handshake flags decoded from state and gated by reset so nothing escapes during it.
  always_comb begin
    bus.req_ready = (state == IDLE) && !reset;
    bus.rsp_valid = (state == RESP) && !reset;
    mem_write     = (state == WRITE) && wr_q && !reset;
  end

  // Request capture on acceptance and RAM read data capture at the end of RD_DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (req_fire) begin
        wr_q    <= bus.req_write;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD_DATA) rdata_q <= mem_dout;
    end
  end

  assign bus.rsp_rdata     = rdata_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_din           = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LW = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic          mem_write;
  logic [DW-1:0] mem_din, mem_dout;
  logic [DW-1:0] ram [DEPTH];

  lsu_if #(.data_width(DW), .addr_width(AW), .len_width(LW)) bus ();

  load_store_unit #(.data_width(DW), .addr_width(AW), .len_width(LW)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write         (mem_write),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with registered read data.
  always @(posedge clk) begin
    if (mem_write) ram[mem_write_address] <= mem_din;
    mem_dout <= ram[mem_read_address];
  end

  // Reference memory contents and scoreboards.
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [AW+DW-1:0] store_q[$];
  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  int wr_pulses = 0;
  bit rand_mode = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every response beat and every RAM write against the queues.
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got %h expected none at %0t", bus.rsp_rdata, $time);
      end else begin
        check("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      end
    end
    if (mem_write) begin
      wr_pulses++;
      if (store_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_write_address, mem_din);
      end else begin
        logic [AW+DW-1:0] e;
        e = store_q.pop_front();
        check("mem_write_address", DW'(mem_write_address), DW'(e[AW+DW-1:DW]));
        check("mem_din", mem_din, e[DW-1:0]);
      end
    end
  end

  // Background random consumer backpressure.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_mode) bus.rsp_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Offer one request and hold it until accepted; records expectations at acceptance.
  task automatic issue(input bit wr, input int addr, input int len, input logic [DW-1:0] wdata,
                       output int waited);
    bit got;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = AW'(addr);
    bus.req_len   = LW'(len);
    bus.req_wdata = wdata;
    waited = 0;
    got = 0;
    while (!got && waited < 300) begin
      @(negedge clk);
      waited++;
      if (bus.req_ready) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: got ready=0 expected ready=1");
    end else if (wr) begin
      model[addr % DEPTH] = wdata;
      store_q.push_back({AW'(addr), wdata});
    end else begin
      for (int b = 0; b <= len; b++) exp_q.push_back(model[(addr + b) % DEPTH]);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 2000) begin
      @(negedge clk); #1;
      n++;
      if (bus.req_ready && exp_q.size() == 0 && store_q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size() + store_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, p0, b0;
    bit seen;
    logic [DW-1:0] d0, saved;
    logic [AW-1:0] a0;

    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_len = '0; bus.req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", DW'(bus.req_ready), 1);
    check("reset_rsp_valid", DW'(bus.rsp_valid), 0);
    check("reset_mem_write", DW'(mem_write), 0);

    // Preload every word so the RAM holds known data.
    for (int i = 0; i < DEPTH; i++) issue(1, i, 0, $urandom, n);
    wait_idle();

    // Single store, then single load with latency check.
    p0 = wr_pulses;
    issue(1, 3, 0, 32'hDEADBEEF, n);
    wait_idle();
    repeat (2) @(negedge clk);
    check("store_one_pulse", DW'(wr_pulses - p0), 1);
    issue(0, 3, 0, '0, n);
    k = 0; seen = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid) seen = 1;
    end
    check("load_latency", DW'(k), 3);
    check("load_deadbeef", bus.rsp_rdata, 32'hDEADBEEF);
    wait_idle();

    // Wrapping burst 14,15,0,1.
    issue(1, 14, 0, 32'h1400_0014, n);
    issue(1, 15, 0, 32'h1500_0015, n);
    issue(1, 0,  0, 32'h0000_0A00, n);
    issue(1, 1,  0, 32'h0100_0A01, n);
    wait_idle();
    b0 = beats_seen;
    issue(0, 14, 3, '0, n);
    wait_idle();
    check("wrap_beats", DW'(beats_seen - b0), 4);

    // Consumer stall: beat held stable.
    bus.rsp_ready = 1'b0;
    issue(0, 5, 1, '0, n);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin @(negedge clk); k++; end
    d0 = bus.rsp_rdata; a0 = mem_read_address;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", DW'(bus.rsp_valid), 1);
      check("stall_rdata", bus.rsp_rdata, d0);
      check("stall_addr", DW'(mem_read_address), DW'(a0));
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_released", DW'(bus.rsp_valid), 0);
    wait_idle();

    // Reset in the middle of a store suppresses the write.
    saved = model[7];
    issue(1, 7, 0, 32'hBAD0_0007, n);
    reset = 1'b1;
    model[7] = saved;
    store_q.delete();
    @(negedge clk);
    check("midstore_mem_write", DW'(mem_write), 0);
    @(posedge clk); #1 reset = 1'b0;
    issue(0, 7, 0, '0, n);
    wait_idle();

    // Reset after the second beat of a 4-beat burst.
    b0 = beats_seen;
    issue(0, 0, 3, '0, n);
    k = 0;
    while (beats_seen < b0 + 2 && k < 40) begin @(negedge clk); #1; k++; end
    check("midburst_two_beats", DW'(beats_seen - b0), 2);
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midburst_rsp_valid_in_reset", DW'(bus.rsp_valid), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midburst_req_ready", DW'(bus.req_ready), 1);
    check("midburst_rsp_valid", DW'(bus.rsp_valid), 0);
    repeat (12) @(negedge clk);
    check("midburst_no_more_beats", DW'(beats_seen - b0), 2);

    // Request held during a burst waits for IDLE and is serviced once.
    issue(0, 2, 2, '0, n);
    p0 = wr_pulses;
    issue(1, 9, 0, 32'h0909_0909, n);
    check("held_req_wait", DW'(n), 9);
    wait_idle();
    repeat (3) @(negedge clk);
    check("held_req_once", DW'(wr_pulses - p0), 1);

    // Randomized traffic with random consumer backpressure.
    rand_mode = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 4) issue(1, $urandom_range(0, DEPTH-1), 0, $urandom, n);
      else issue(0, $urandom_range(0, DEPTH-1), $urandom_range(0, 3), '0, n);
    end
    wait_idle();
    rand_mode = 0;
    check("drain_loads", DW'(exp_q.size()), 0);
    check("drain_stores", DW'(store_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
